// File: rtl/speaker_i2s_tx_pkg.sv
// Shared constants and helpers for the I2S speaker transmitter.
// Honours I2S_LEFT_JUSTIFIED_EN (left-justified framing instead of standard I2S).
package speaker_i2s_tx_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 9;
  localparam int SLOT_W   = 4;
  localparam int MCLK_BIT = 1;
  localparam int SCK_BIT  = 3;
  localparam int LRCK_BIT = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [SLOT_W-1:0]   slot_t;

  // Word bit carried by a slot; standard I2S is delayed by one slot (slot 0 handled by caller).
  function automatic slot_t slot_bit_index(input slot_t slot);
`ifdef I2S_LEFT_JUSTIFIED_EN
    return slot_t'(SAMPLE_W - 1) - slot;
`else
    return slot_t'(0) - slot;
`endif
  endfunction

endpackage

// File: rtl/speaker_i2s_tx_clk_gen.sv
// Free-running frame counter producing MCLK/SCK/LRCK plus capture and shift strobes,
// and the slot/half position of the slot that begins on the next clock edge.
module audio_clk_gen
  import speaker_i2s_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              mclk,
  output logic              sck,
  output logic              lrck,
  output logic              capture_stb,
  output logic              shift_stb,
  output logic [SLOT_W-1:0] slot_next,
  output logic              half_next
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign cnt_next = cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign mclk        = cnt_reg[MCLK_BIT];
  assign sck         = cnt_reg[SCK_BIT];
  assign lrck        = cnt_reg[LRCK_BIT];
  assign capture_stb = (cnt_reg == '1);
  // Last cycle of a slot: the edge that ends it is the SCK falling edge.
  assign shift_stb   = (cnt_reg[SCK_BIT:0] == '1);
  assign slot_next   = cnt_next[LRCK_BIT-1:SCK_BIT+1];
  assign half_next   = cnt_next[LRCK_BIT];

endmodule

// File: rtl/speaker_i2s_tx.sv
// Stereo I2S serializer for the Pmod DAC: latches one L/R pair per 512-cycle frame.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified output (default is standard I2S).
module speaker_i2s_tx
  import speaker_i2s_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        sample_tick
);

  logic              capture_stb;
  logic              shift_stb;
  logic [SLOT_W-1:0] slot_next;
  logic              half_next;

  sample_t word_l_reg;
  sample_t word_r_reg;
  sample_t cur_word;
  logic    sdin_next;

  audio_clk_gen u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .mclk        (audio_mclk),
    .sck         (audio_sck),
    .lrck        (audio_lrck),
    .capture_stb (capture_stb),
    .shift_stb   (shift_stb),
    .slot_next   (slot_next),
    .half_next   (half_next)
  );

  assign sample_tick = capture_stb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_l_reg <= '0;
      word_r_reg <= '0;
    end else if (capture_stb) begin
      word_l_reg <= audio_left;
      word_r_reg <= audio_right;
    end
  end

  always_comb begin
    cur_word  = half_next ? word_r_reg : word_l_reg;
    sdin_next = cur_word[slot_bit_index(slot_next)];
`ifndef I2S_LEFT_JUSTIFIED_EN
    // The right LSB spilling into the next left slot 0 is loaded on the same edge that
    // reloads word_r_reg, so it still reads the previous frame's right word.
    if (slot_next == '0) begin
      sdin_next = half_next ? word_l_reg[0] : word_r_reg[0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_sdin <= 1'b0;
    end else if (shift_stb) begin
      audio_sdin <= sdin_next;
    end
  end

endmodule
